// File: rtl/minterm_pkg.sv
// Shared types and constants for the minterm expander.
// The truth bitmaps are golden references for the bench; the RTL evaluates the SOP equations.
package minterm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int IDX_W = 4;
    localparam int CNT_W = 5;

    localparam logic [IDX_W-1:0] IDX_LAST = 4'd15;

    localparam logic [15:0] F1_ON = 16'h35A5;
    localparam logic [15:0] F2_ON = 16'hEEE2;

endpackage

// File: rtl/minterm_expander_bool_eval.sv
// Combinational evaluation of the minimized f1/f2 equations at one input index.
// Index bits are {a,b,c,d} for f1 and {w,x,y,z} for f2, MSB first.
module bool_eval
    import minterm_pkg::*;
(
    input  logic             sel,
    input  logic [IDX_W-1:0] idx,
    output logic             f
);

    logic v3_s;
    logic v2_s;
    logic v1_s;
    logic v0_s;
    logic f1_s;
    logic f2_s;

    // Gate-level SOP forms; f2 reuses the same bit positions as w,x,y,z
    always_comb begin
        {v3_s, v2_s, v1_s, v0_s} = idx;
        f1_s = (~v2_s & ~v0_s) | (~v3_s & v2_s & v0_s) | (v3_s & v2_s & ~v1_s);
        f2_s = (~v1_s & v0_s) | (v2_s & v1_s) | (v3_s & v1_s);
        if (sel) begin
            f = f2_s;
        end else begin
            f = f1_s;
        end
    end

endmodule

// File: rtl/minterm_expander.sv
// Sweeps the 4-variable input space of the selected minimized function and streams
// the minterm (or maxterm) indices over valid/ready, then pulses done with the term count.
module minterm_expander
    import minterm_pkg::*;
#(
    parameter logic EMIT_MAXTERMS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sel,
    output logic             busy,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [IDX_W-1:0] m_idx,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    state_t           state_r;
    state_t           state_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_s;
    logic [IDX_W-1:0] m_idx_r;
    logic [IDX_W-1:0] m_idx_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             sel_r;
    logic             sel_s;
    logic             f_s;
    logic             hit_s;
    logic             busy_r;
    logic             m_valid_r;
    logic             done_r;

    bool_eval u_eval (
        .sel (sel_r),
        .idx (idx_r),
        .f   (f_s)
    );

    assign hit_s = f_s ^ EMIT_MAXTERMS;

    // Next-state, index, count and emitted-index decode
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        count_s = count_r;
        m_idx_s = m_idx_r;
        sel_s   = sel_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    sel_s   = sel;
                    idx_s   = 4'd0;
                    count_s = 5'd0;
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (hit_s) begin
                    m_idx_s = idx_r;
                    count_s = count_r + 5'd1;
                    state_s = EMIT;
                end else if (idx_r == IDX_LAST) begin
                    state_s = DONE;
                end else begin
                    idx_s = idx_r + 4'd1;
                end
            end
            EMIT: begin
                if (m_ready) begin
                    if (idx_r == IDX_LAST) begin
                        state_s = DONE;
                    end else begin
                        idx_s   = idx_r + 4'd1;
                        state_s = SCAN;
                    end
                end else begin
                    state_s = EMIT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; status outputs are registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= 4'd0;
            m_idx_r   <= 4'd0;
            count_r   <= 5'd0;
            sel_r     <= 1'b0;
            busy_r    <= 1'b0;
            m_valid_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            m_idx_r   <= m_idx_s;
            count_r   <= count_s;
            sel_r     <= sel_s;
            busy_r    <= (state_s != IDLE);
            m_valid_r <= (state_s == EMIT);
            done_r    <= (state_s == DONE);
        end
    end

    assign busy    = busy_r;
    assign m_valid = m_valid_r;
    assign m_idx   = m_idx_r;
    assign done    = done_r;
    assign count   = count_r;

endmodule

// File: tb/tb_minterm_expander.sv
// Directed bench for minterm_expander: minterm and maxterm sweeps, back-pressure,
// mid-sweep reset, and start/sel noise while busy.
module tb_minterm_expander;
    import minterm_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sel;
    logic       m_ready;
    logic       use_mx;

    logic       busy0, m_valid0, done0;
    logic [3:0] m_idx0;
    logic [4:0] count0;
    logic       busy1, m_valid1, done1;
    logic [3:0] m_idx1;
    logic [4:0] count1;

    logic       busy_s, m_valid_s, done_s;
    logic [3:0] m_idx_s;
    logic [4:0] count_s;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    minterm_expander #(.EMIT_MAXTERMS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .sel(sel), .busy(busy0),
        .m_valid(m_valid0), .m_ready(m_ready), .m_idx(m_idx0), .done(done0), .count(count0)
    );

    minterm_expander #(.EMIT_MAXTERMS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .sel(sel), .busy(busy1),
        .m_valid(m_valid1), .m_ready(m_ready), .m_idx(m_idx1), .done(done1), .count(count1)
    );

    assign busy_s    = use_mx ? busy1    : busy0;
    assign m_valid_s = use_mx ? m_valid1 : m_valid0;
    assign done_s    = use_mx ? done1    : done0;
    assign m_idx_s   = use_mx ? m_idx1   : m_idx0;
    assign count_s   = use_mx ? count1   : count0;

    task automatic check_eq(input string tag, input int act, input int exp);
        chk_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        start   = 1'b0;
        m_ready = 1'b1;
        while ((busy0 || busy1) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq("idle_before_start", int'(busy0 | busy1), 0);
    endtask

    // One full sweep on the selected instance, checked against the golden bitmap
    task automatic sweep(input logic s, input logic mx, input int rdy_pct,
                         input logic noise, input logic [15:0] on_map);
        int         exp_q[$];
        int         got_q[$];
        int         n;
        int         done_n;
        int         first_v;
        int         acc_n;
        logic       rdy_nxt;
        logic       stalled;
        logic [3:0] held;
        use_mx = mx;
        wait_idle();
        for (int i = 0; i < 16; i++) begin
            if (on_map[i] ^ mx) exp_q.push_back(i);
        end
        @(negedge clk);
        start = 1'b1;
        sel   = s;
        @(negedge clk);
        start   = 1'b0;
        n       = 1;
        done_n  = -1;
        first_v = -1;
        acc_n   = -1;
        stalled = 1'b0;
        held    = 4'd0;
        while (done_n < 0 && n < 200) begin
            check_eq("busy_in_sweep", int'(busy_s), 1);
            if (stalled) begin
                check_eq("stall_valid", int'(m_valid_s), 1);
                check_eq("stall_idx", int'(m_idx_s), int'(held));
            end
            if (done_s) begin
                done_n = n;
                check_eq("valid_in_done", int'(m_valid_s), 0);
            end
            if (m_valid_s && first_v < 0) first_v = n;
            rdy_nxt = ($urandom_range(0, 99) < rdy_pct);
            if (m_valid_s && rdy_nxt) begin
                got_q.push_back(int'(m_idx_s));
                acc_n = n;
            end
            stalled = m_valid_s && !rdy_nxt;
            held    = m_idx_s;
            m_ready = rdy_nxt;
            if (noise) begin
                start = ($urandom_range(0, 1) == 1);
                sel   = ~sel;
            end
            if (done_n < 0) begin
                @(negedge clk);
                n++;
            end
        end
        check_eq("done_seen", int'(done_n > 0), 1);
        check_eq("count", int'(count_s), exp_q.size());
        check_eq("n_terms", got_q.size(), exp_q.size());
        for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
            check_eq("term_idx", got_q[j], exp_q[j]);
        end
        if (rdy_pct == 100) begin
            check_eq("done_cycle", done_n, 17 + exp_q.size());
            check_eq("first_valid_cycle", first_v, exp_q[0] + 2);
        end
        if (exp_q[exp_q.size() - 1] == 15) begin
            check_eq("last_then_done", done_n, acc_n + 1);
        end
        // start during the DONE cycle must be ignored
        start   = noise;
        m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_done", int'(busy_s), 0);
        check_eq("done_one_cycle", int'(done_s), 0);
        check_eq("count_held", int'(count_s), exp_q.size());
        @(negedge clk);
        check_eq("still_idle", int'(busy_s), 0);
    endtask

    // Stall an f1 sweep on index 7 and reset asynchronously mid-sweep
    task automatic reset_mid_sweep();
        int guard = 0;
        int done_hits = 0;
        use_mx = 1'b0;
        wait_idle();
        @(negedge clk);
        start = 1'b1;
        sel   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!(m_valid0 && m_idx0 == 4'd7) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        m_ready = 1'b0;
        check_eq("reached_idx7", int'(m_valid0 && m_idx0 == 4'd7), 1);
        @(negedge clk);
        check_eq("stalled_on_7", int'(m_valid0), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_busy", int'(busy0), 0);
        check_eq("rst_valid", int'(m_valid0), 0);
        check_eq("rst_idx", int'(m_idx0), 0);
        check_eq("rst_done", int'(done0), 0);
        check_eq("rst_count", int'(count0), 0);
        @(negedge clk);
        rst     = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done0 || busy0) done_hits++;
        end
        check_eq("no_done_after_rst", done_hits, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        sel     = 1'b0;
        m_ready = 1'b1;
        use_mx  = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_busy", int'(busy0), 0);
        check_eq("reset_valid", int'(m_valid0), 0);
        check_eq("reset_idx", int'(m_idx0), 0);
        check_eq("reset_done", int'(done0), 0);
        check_eq("reset_count", int'(count0), 0);
        rst = 1'b0;
        @(negedge clk);

        sweep(1'b0, 1'b0, 100, 1'b0, F1_ON);
        sweep(1'b1, 1'b0, 100, 1'b0, F2_ON);
        sweep(1'b0, 1'b1, 100, 1'b0, F1_ON);
        sweep(1'b1, 1'b1, 100, 1'b0, F2_ON);
        sweep(1'b1, 1'b0, 30, 1'b0, F2_ON);
        reset_mid_sweep();
        sweep(1'b0, 1'b0, 100, 1'b0, F1_ON);
        sweep(1'b1, 1'b0, 100, 1'b1, F2_ON);
        sweep(1'b0, 1'b1, 60, 1'b1, F1_ON);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/minterm_expander.md
# minterm_expander

- Sequential inverse of the minimized f1/f2 logic. The minimized equations are stored; this block sweeps the 4-variable input space and streams the canonical minterm indices (or maxterm indices) of the selected function over a valid/ready port.
- At the end of a sweep it reports the term count.
- It sits beside the minimized combinational logic as a self-check and canonical-form generator.

## Interface
- `EMIT_MAXTERMS`, default 0: 0 emits indices where the function is 1; 1 emits indices where it is 0.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: begin a sweep; honoured only in IDLE.
- `sel` input 1: function select, sampled with `start`. 0 = f1(a,b,c,d), 1 = f2(w,x,y,z).
- `busy` output 1: high from the cycle after an accepted `start` through the DONE cycle.
- `m_valid` output 1: emitted index valid.
- `m_ready` input 1: sink accepts the index.
- `m_idx` output 4: emitted index. MSB is a (f1) or w (f2); LSB is d or z.
- `done` output 1: one-cycle pulse at the end of a sweep.
- `count` output 5: number of indices emitted in the last sweep (0..16), held until the next accepted `start`.

## Operation
- Evaluated equations (SOP, minimized):
  - f1 = b'd' + a'bd + abc'
  - f2 = y'z + xy + wy
- `hit` = f(idx) XOR `EMIT_MAXTERMS`.
- States: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - `start`=1: latch `sel`, idx←0, `count`←0, go to SCAN.
  - Otherwise stay.
- SCAN (one index per cycle):
  - `hit`=1: `m_idx`←idx, `count`←`count`+1, go to EMIT.
  - `hit`=0 and idx=15: go to DONE.
  - `hit`=0 and idx<15: idx←idx+1.
- EMIT:
  - `m_valid`=1 and `m_idx` are stable until `m_ready`.
  - On `m_valid`&`m_ready`: if idx=15 go to DONE, else idx←idx+1 and go to SCAN.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` while not in IDLE is ignored; `sel` changes after acceptance are ignored.
- idx is 4 bits. The sweep never wraps: 15 is terminal.
- `count` is 5 bits so that 16 is representable; maximum 16, reached with `EMIT_MAXTERMS` on a constant function.

## Timing
- Reset values: state=IDLE, idx=0, `busy`=0, `m_valid`=0, `m_idx`=0, `done`=0, `count`=0.
- All outputs are registered or decoded from state; no combinational path from `m_ready` to `m_valid`.
- Accepted `start` in cycle T: SCAN idx 0 in T+1.
- A hit in SCAN cycle S: `m_valid`=1 from S+1.
- With `m_ready` held at 1:
  - each hit costs 2 cycles; each non-hit costs 1;
  - sweep length = 16 + k cycles (k = terms), then DONE = 1 cycle.
- `done` and the final `count` are visible in the same cycle; `busy` drops the cycle after.
- Back-pressure: `m_ready` low stalls EMIT indefinitely. idx, `m_idx` and `count` are held.
- `rst` asserted mid-sweep: immediate return to reset values. No `done`, no partial `count` retained.
- `start` asserted in the DONE cycle is ignored; it must be re-asserted in IDLE.

## Structure
- Package `minterm_pkg`:
  - state enum (IDLE, SCAN, EMIT, DONE);
  - index width constant (4) and count width constant (5);
  - golden truth bitmaps F1_ON = 16'h35A5 and F2_ON = 16'hEEE2, for the bench only. The RTL evaluates the SOP equations, not the bitmaps.
- One sub-module, `bool_eval`: purely combinational, inputs `sel` and idx[3:0], output `f`, built from the minimized gate equations above.
- The top holds the FSM, index counter, count register and output register.

## Test plan
- `sel`=0, `EMIT_MAXTERMS`=0, `m_ready`=1: stream 0,2,5,7,8,10,12,13; `count`=8; `done` exactly 24 cycles after the first SCAN cycle (cycle T+25 for `start` at T).
- `sel`=1, `EMIT_MAXTERMS`=0, `m_ready`=1: stream 1,5,6,7,9,10,11,13,14,15; `count`=10; last emitted index is 15, followed by DONE.
- `EMIT_MAXTERMS`=1:
  - `sel`=0 streams 1,3,4,6,9,11,14,15 with `count`=8;
  - `sel`=1 streams 0,2,3,4,8,12 with `count`=6.
- `sel`=1, `m_ready` random 30% duty: same sequence as the second scenario, `m_idx` stable and `m_valid` never dropping while stalled, no duplicates, `count`=10.
- Reset and start:
  - `rst` pulsed while `m_valid`=1 on `m_idx`=7 (f1 sweep): all outputs return to 0 and no `done` is emitted;
  - a new `start` restarts from index 0;
  - `start` pulses during `busy` are ignored and `sel` toggling mid-sweep has no effect.
